// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default datapath widths and the fetch FSM states.
package cpu_pkg;

  localparam int unsigned INST_W_DEF = 18;
  localparam int unsigned PC_W_DEF   = 12;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry registered FIFO holding fetched {pc, instruction} pairs.
// Flush empties it; a push on a full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a 2-entry FIFO,
// with redirect/drain handling. Define FETCH_PERF_CNT_EN to add the fetch/stall counters.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned            INST_W   = INST_W_DEF,
  parameter int unsigned            PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0]        RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [PC_W-1:0]   mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_data_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_addr_i,
  output logic              ack_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int unsigned ENT_W = PC_W + INST_W;

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [ENT_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             req;
  logic             push;
  logic             flush;
  logic             pop;

  // A request stays up until acked: occupancy cannot grow without an ack, so !full holds.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      FETCH: begin
        req = !fifo_full;
        if (redirect_i) begin
          flush = 1'b1;
          pc_d  = redirect_addr_i;
          if (req && !mem_ack_i) begin
            state_d = DRAIN;
          end
        end else if (req && mem_ack_i) begin
          push = 1'b1;
          pc_d = pc_q + PC_W'(1);
        end
      end
      DRAIN: begin
        if (redirect_i) begin
          pc_d = redirect_addr_i;
        end
        if (mem_ack_i) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH(ENT_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush_i(flush),
    .push_i (push),
    .data_i ({pc_q, mem_data_i}),
    .pop_i  (pop),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign ack_o      = !rst && !fifo_empty && !stall_i && !redirect_i;
  assign pop        = ack_o;
  assign mem_req_o  = req && !rst;
  assign mem_addr_o = pc_q;
  assign inst_o     = rst ? '0 : head[INST_W-1:0];
  assign pc_o       = rst ? '0 : head[ENT_W-1:INST_W];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (ack_o) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!fifo_empty && stall_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: variable-latency memory, directed scenarios,
// random stall/redirect/reset traffic checked against an in-order delivery model.
module tb_instr_fetch;

  localparam int unsigned      INST_W   = 18;
  localparam int unsigned      PC_W     = 12;
  localparam logic [PC_W-1:0]  RESET_PC = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req_o;
  logic [PC_W-1:0]   mem_addr_o;
  logic              mem_ack_i = 1'b0;
  logic [INST_W-1:0] mem_data_i = '0;
  logic              stall_i = 1'b0;
  logic              redirect_i = 1'b0;
  logic [PC_W-1:0]   redirect_addr_i = '0;
  logic              ack_o;
  logic [INST_W-1:0] inst_o;
  logic [PC_W-1:0]   pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       fetch_cnt_o;
  logic [31:0]       stall_cnt_o;
`endif

  instr_fetch #(
    .INST_W  (INST_W),
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .ack_o          (ack_o),
    .inst_o         (inst_o),
    .pc_o           (pc_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o    (fetch_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Stimulus requested for the next cycle
  logic            rst_v = 1'b1;
  logic            stall_v = 1'b0;
  logic            redir_v = 1'b0;
  logic [PC_W-1:0] raddr_v = '0;

  // Memory environment
  bit              m_busy = 1'b0;
  int unsigned     m_cnt = 0;
  logic [PC_W-1:0] m_addr = '0;
  int unsigned     lat_min = 0;
  int unsigned     lat_max = 0;

  // Reference model: instructions come out in address order from the last restart point
  int              occ = 0;
  bit              draining = 1'b0;
  logic [PC_W-1:0] fetch_pc = RESET_PC;
  logic [PC_W-1:0] exp_pc = RESET_PC;
  logic [31:0]     exp_fcnt = '0;
  logic [31:0]     exp_scnt = '0;

  function automatic logic [INST_W-1:0] img(input logic [PC_W-1:0] a);
    return {a, 6'h2B} ^ 18'h1F0F3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic exp_req;
    logic exp_ack;
    int unsigned lat;
    @(negedge clk);
    rst             = rst_v;
    stall_i         = stall_v;
    redirect_i      = redir_v;
    redirect_addr_i = raddr_v;
    #1;
    mem_ack_i  = 1'b0;
    mem_data_i = INST_W'($urandom);
    if (rst) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (mem_req_o) chk("addr_hold", 32'(mem_addr_o), 32'(m_addr));
      if (m_cnt == 0) begin
        mem_ack_i  = 1'b1;
        mem_data_i = img(m_addr);
        m_busy     = 1'b0;
      end else begin
        m_cnt--;
      end
    end else if (mem_req_o) begin
      lat = $urandom_range(lat_max, lat_min);
      if (lat == 0) begin
        mem_ack_i  = 1'b1;
        mem_data_i = img(mem_addr_o);
      end else begin
        m_busy = 1'b1;
        m_cnt  = lat - 1;
        m_addr = mem_addr_o;
      end
    end
    #1;
    if (rst) begin
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_ack", 32'(ack_o), 32'd0);
      chk("rst_inst", 32'(inst_o), 32'd0);
      chk("rst_pc", 32'(pc_o), 32'd0);
      occ = 0; draining = 1'b0; fetch_pc = RESET_PC; exp_pc = RESET_PC;
      exp_fcnt = '0; exp_scnt = '0;
    end else begin
      exp_req = !draining && (occ < 2);
      exp_ack = (occ > 0) && !stall_i && !redirect_i;
      chk("mem_req", 32'(mem_req_o), 32'(exp_req));
      if (exp_req) chk("mem_addr", 32'(mem_addr_o), 32'(fetch_pc));
      chk("ack", 32'(ack_o), 32'(exp_ack));
      if (occ > 0) begin
        chk("pc_head", 32'(pc_o), 32'(exp_pc));
        chk("inst_head", 32'(inst_o), 32'(img(exp_pc)));
      end
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt_o, exp_fcnt);
      chk("stall_cnt", stall_cnt_o, exp_scnt);
`endif
      if (exp_ack) exp_fcnt++;
      if (stall_i && occ > 0) exp_scnt++;
      if (redirect_i) begin
        if (!draining && exp_req && !mem_ack_i) draining = 1'b1;
        else if (draining && mem_ack_i) draining = 1'b0;
        occ = 0; fetch_pc = redirect_addr_i; exp_pc = redirect_addr_i;
      end else if (draining) begin
        if (mem_ack_i) draining = 1'b0;
      end else begin
        if (exp_ack) begin occ--; exp_pc++; end
        if (exp_req && mem_ack_i) begin occ++; fetch_pc++; end
      end
    end
  endtask

  initial begin
    int unsigned n;
    bit found;

    // Zero-wait memory: first request at RESET_PC, then one delivery per cycle
    lat_min = 0; lat_max = 0;
    rst_v = 1'b1;
    repeat (3) cycle();
    rst_v = 1'b0;
    cycle();
    chk("first_req", 32'(mem_req_o), 32'd1);
    chk("first_addr", 32'(mem_addr_o), 32'(RESET_PC));
    cycle();
    chk("first_ack_pc", 32'(pc_o), 32'd0);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (ack_o) n++;
    end
    chk("sustained", n, 32'd16);

    // Five stall cycles fill the FIFO; release resumes at 17 with no gap
    stall_v = 1'b1;
    repeat (5) cycle();
    chk("stall_req_off", 32'(mem_req_o), 32'd0);
    chk("stall_pc", 32'(pc_o), 32'd17);
    stall_v = 1'b0;
    cycle();
    chk("rel_pc0", 32'(pc_o), 32'd17);
    cycle();
    chk("rel_pc1", 32'(pc_o), 32'd18);
    cycle();
    chk("rel_pc2", 32'(pc_o), 32'd19);

    // Redirect to 0x100 while a 3-cycle request is outstanding
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (m_busy && m_cnt == 2) found = 1'b1;
    end
    chk("wait_busy", 32'(found), 32'd1);
    redir_v = 1'b1; raddr_v = 12'h100;
    cycle();
    chk("redir_ack_off", 32'(ack_o), 32'd0);
    redir_v = 1'b0;
    cycle();
    chk("drain_req_off", 32'(mem_req_o), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (ack_o) found = 1'b1;
    end
    chk("redir_wait", 32'(found), 32'd1);
    chk("redir_pc", 32'(pc_o), 32'h100);
    chk("redir_inst", 32'(inst_o), 32'(img(12'h100)));

    // PC wrap from 0xFFF to 0x000
    lat_min = 0; lat_max = 0;
    redir_v = 1'b1; raddr_v = 12'hFFD;
    cycle();
    redir_v = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (ack_o && pc_o == 12'hFFF) found = 1'b1;
    end
    chk("wrap_wait", 32'(found), 32'd1);
    cycle();
    chk("wrap_ack", 32'(ack_o), 32'd1);
    chk("wrap_pc", 32'(pc_o), 32'h000);

    // Reset while a request is pending
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (m_busy && mem_req_o) found = 1'b1;
    end
    chk("rst_wait", 32'(found), 32'd1);
    rst_v = 1'b1;
    cycle();
    cycle();
    chk("rst_mid_req", 32'(mem_req_o), 32'd0);
    chk("rst_mid_ack", 32'(ack_o), 32'd0);
    rst_v = 1'b0;
    cycle();
    chk("post_rst_req", 32'(mem_req_o), 32'd1);
    chk("post_rst_addr", 32'(mem_addr_o), 32'(RESET_PC));

    // Random traffic
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      rst_v   = ($urandom_range(99) == 0);
      stall_v = ($urandom_range(9) < 3);
      redir_v = ($urandom_range(99) < 4);
      raddr_v = ($urandom_range(3) == 0) ? 12'hFFE : PC_W'($urandom);
      cycle();
    end
    rst_v = 1'b0; stall_v = 1'b0; redir_v = 1'b0;
    lat_min = 0; lat_max = 2;
    n = 0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      cycle();
      if (ack_o) n++;
    end
    chk("liveness", n, 32'd8);

`ifdef FETCH_PERF_CNT_EN
    lat_min = 0; lat_max = 0;
    rst_v = 1'b1;
    repeat (2) cycle();
    rst_v = 1'b0;
    cycle();
    for (int i = 0; i < 14; i++) begin
      stall_v = (i == 2 || i == 3 || i == 7 || i == 11);
      cycle();
    end
    stall_v = 1'b0;
    cycle();
    chk("perf_fetch10", fetch_cnt_o, 32'd10);
    chk("perf_stall4", stall_cnt_o, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
